// File: rtl/div_iter_unit.sv
// Radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
// Optional divide-by-zero flag output: define DIV_ZERO_FLAG_EN.
module div_iter_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic                divzero_o
`endif
);

  typedef enum logic [1:0] {
    S_FREE, S_DIVZERO, S_ON, S_END
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] work_q, work_d;
  logic [DATA_W-1:0]   dvsr_q, dvsr_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;
`ifdef DIV_ZERO_FLAG_EN
  logic                divz_q, divz_d;
`endif

  logic              s1, s2;
  logic [DATA_W-1:0] abs1, abs2;
  logic [DATA_W:0]   rem_sh, trial;
  logic              ge;
  logic [DATA_W-1:0] rem_nx, quot_nx;
  logic [DATA_W-1:0] rem_fix, quot_fix;

  always_comb begin
    s1   = signed_div_i & opdata1_i[DATA_W-1];
    s2   = signed_div_i & opdata2_i[DATA_W-1];
    abs1 = s1 ? -opdata1_i : opdata1_i;
    abs2 = s2 ? -opdata2_i : opdata2_i;
    // Shifted-out MSB is kept so the trial never loses a carry.
    rem_sh  = work_q[2*DATA_W-1:DATA_W-1];
    trial   = rem_sh - {1'b0, dvsr_q};
    ge      = rem_sh >= {1'b0, dvsr_q};
    rem_nx  = ge ? trial[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    quot_nx = {work_q[DATA_W-2:0], ge};
    quot_fix = qneg_q ? -quot_nx : quot_nx;
    rem_fix  = rneg_q ? -rem_nx : rem_nx;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    dvsr_d   = dvsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    ready_d  = ready_q;
`ifdef DIV_ZERO_FLAG_EN
    divz_d   = divz_q;
`endif
    unique case (state_q)
      S_FREE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = S_DIVZERO;
          end else begin
            state_d = S_ON;
            cnt_d   = '0;
            dvsr_d  = abs2;
            work_d  = {{DATA_W{1'b0}}, abs1};
            qneg_d  = s1 ^ s2;
            rneg_d  = s1;
          end
        end
      end
      S_DIVZERO: begin
        state_d  = S_END;
        result_d = '0;
        ready_d  = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
        divz_d   = 1'b1;
`endif
      end
      S_ON: begin
        if (annul_i) begin
          state_d = S_FREE;
          cnt_d   = '0;
        end else begin
          work_d = {rem_nx, quot_nx};
          cnt_d  = cnt_q + 1'b1;
          // Final iteration also applies the sign fix.
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d  = S_END;
            result_d = {rem_fix, quot_fix};
            ready_d  = 1'b1;
          end
        end
      end
      S_END: begin
        if (!start_i) begin
          state_d  = S_FREE;
          result_d = '0;
          ready_d  = 1'b0;
`ifdef DIV_ZERO_FLAG_EN
          divz_d   = 1'b0;
`endif
        end
      end
      default: state_d = S_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      work_q   <= '0;
      dvsr_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      divz_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      dvsr_q   <= dvsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
`ifdef DIV_ZERO_FLAG_EN
      divz_q   <= divz_d;
`endif
    end
  end

  assign result_o  = result_q;
  assign ready_o   = ready_q;
`ifdef DIV_ZERO_FLAG_EN
  assign divzero_o = divz_q;
`endif

endmodule
